mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Initiator that drives one port of the team's 8x256 dual-port RAM (registered read, write-first-or-read per cycle, 1-cycle read latency).
- Performs block copy (src -> dst) or block fill (constant -> dst) of up to 256 bytes on a single start pulse.
- The other RAM port stays free for the consumer. Used for buffer initialisation and relocation.

Parameters:
- AW, 8, address width; RAM depth is 2**AW.
- DW, 8, data width.

Ports:
- clk  in  1  single clock; all logic on posedge clk.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src_addr  in  AW  copy source base (ignored in fill).
- dst_addr  in  AW  destination base.
- len  in  AW+1  byte count, 0..2**AW.
- fill_val  in  DW  fill constant.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- mem_addr  out  AW  to RAM add_x.
- mem_din  out  DW  to RAM din_x.
- mem_we  out  1  to RAM we_x.
- mem_dout  in  DW  from RAM dout_x.

Behaviour:
- Reset values: busy=0, done=0, mem_we=0, mem_addr=0, mem_din=0, state=IDLE, counters=0.
- States: IDLE, RD, CAP, WR, FIN.
- IDLE
  - On start=1, latch src/dst/len/mode/fill_val.
  - len=0: go to FIN, no RAM access.
  - Otherwise go to RD if copy, WR if fill.
- RD: mem_addr=src_ptr, mem_we=0 -> CAP.
- CAP
  - mem_addr is held and mem_we=0.
  - The RAM updated dout at the RD->CAP edge; data_q <= mem_dout at the end of CAP -> WR.
- WR: mem_addr=dst_ptr, mem_we=1, mem_din=data_q (copy) or fill_q (fill).
  - Increment src_ptr and dst_ptr, decrement remaining.
  - If remaining was 1: -> FIN. Otherwise -> RD (copy) or stay in WR (fill).
- FIN: done=1 for exactly one cycle, busy=0 -> IDLE.
- busy=1 in RD/CAP/WR and 0 in IDLE/FIN.
- mem_we=1 only in WR.
- Latency from the start-sampling edge to done high:
  - copy: 3*len+1 cycles.
  - fill: len+1 cycles.
  - len=0: 1 cycle.
- Pointers wrap modulo 2**AW (dst 0xFF + 1 -> 0x00).
- len=256 covers the whole array.
- Overlap is resolved by forward byte order only. If dst is in (src, src+len), earlier written bytes are re-read; this is defined behaviour, not an error.
- start while busy or in FIN is ignored; no queuing.
- Command inputs are not sampled outside IDLE.
- rst mid-command: the next edge returns to IDLE with mem_we=0 and done=0.
  - Bytes already written stay written; the rest are not touched.
- When mem_we=0, mem_din holds its last value (don't-care for the RAM).

Decomposition:
- Shared package mem_pkg holds:
  - AW/DW defaults (8/8).
  - State enum encoding (IDLE=0, RD=1, CAP=2, WR=3, FIN=4, 3-bit).
  - Mode constants MODE_COPY=0, MODE_FILL=1.
- Single module with no sub-module. The FSM plus pointer/counter datapath is small enough to stay flat.
- Bench instantiates the existing dual-port RAM with this engine on port A and a checker on port B.

Test Plan:
- Fill: rst 2 cycles, then start mode=1 dst=0x10 len=4 fill_val=0xA5.
  - Expect writes to 0x10..0x13 on 4 consecutive cycles.
  - done 5 cycles after start; port B reads 0xA5 at 0x10..0x13 and 0x00 at 0x14.
- Copy: preload 0x20..0x22 = 0x11,0x22,0x33 via port B, then start copy src=0x20 dst=0x40 len=3.
  - Expect mem_we pattern 0,0,1 repeated 3 times.
  - done at cycle 10; 0x40..0x42 = 0x11,0x22,0x33.
- Wrap: fill dst=0xFE len=4 val=0x5C.
  - Expect writes at 0xFE,0xFF,0x00,0x01; 0x02 untouched.
- len=0 and busy start:
  - start len=0 -> done next cycle, mem_we never 1.
  - During a len=8 copy, pulse start with dst=0x80 -> ignored; 0x80 unchanged and done fires once.
- Reset mid-op: fill dst=0x30 len=10 val=0xFF, assert rst after the 3rd write.
  - Expect 0x30..0x32=0xFF and 0x33=0x00.
  - busy=0, done=0, mem_we=0 the cycle after the rst edge.
- Overlap: preload 0x50=0x01, 0x51=0x02, then copy src=0x50 dst=0x51 len=2.
  - Expect 0x51=0x01 and 0x52=0x01 (forward propagation).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory copy/fill engine: default geometry,
// FSM state encoding and command mode constants.
package mem_pkg;

    localparam int unsigned MEM_AW = 8;
    localparam int unsigned MEM_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dp_ram.sv
// Dual-port RAM, 2**AW x DW. Each port has a registered read with 1-cycle
// latency; a write returns the written data on that port (write-first).
// Ports: clk; per port x in {a,b}: add_x address, din_x write data,
// we_x write enable, dout_x registered read data.
module dp_ram #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] add_a,
    input  logic [DW-1:0] din_a,
    input  logic          we_a,
    output logic [DW-1:0] dout_a,
    input  logic [AW-1:0] add_b,
    input  logic [DW-1:0] din_b,
    input  logic          we_b,
    output logic [DW-1:0] dout_b
);

    logic [DW-1:0] mem [2**AW];

    // Both ports share one process so the array has a single driver.
    always_ff @(posedge clk) begin
        if (we_a) mem[add_a] <= din_a;
        if (we_b) mem[add_b] <= din_b;
        dout_a <= we_a ? din_a : mem[add_a];
        dout_b <= we_b ? din_b : mem[add_b];
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy (src -> dst) or block fill (constant -> dst) engine driving one
// port of a dual-port RAM with 1-cycle registered read latency.
// Ports: clk, rst (sync active-high); command: start, mode (0 copy, 1 fill),
// src_addr, dst_addr, len (0..2**AW), fill_val; status: busy, done (1-cycle
// pulse); RAM side: mem_addr, mem_din, mem_we (registered), mem_dout.
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int unsigned AW = MEM_AW,
    parameter int unsigned DW = MEM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout
);

    state_t        state, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW:0]   rem_q, rem_d;
    logic          mode_q, mode_d;
    logic [DW-1:0] fill_q, fill_d;
    logic          busy_d, done_d, we_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] din_d;

    // State, datapath and registered RAM-side outputs. The mem_din register
    // doubles as the captured read data for the copy path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            mode_q   <= MODE_COPY;
            fill_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            state    <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            mode_q   <= mode_d;
            fill_q   <= fill_d;
            busy     <= busy_d;
            done     <= done_d;
            mem_we   <= we_d;
            mem_addr <= addr_d;
            mem_din  <= din_d;
        end
    end

    // Next state plus the output values that go with the state being entered.
    always_comb begin
        state_d = state;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        we_d    = 1'b0;
        addr_d  = mem_addr;
        din_d   = mem_din;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    rem_d  = len;
                    mode_d = mode;
                    fill_d = fill_val;
                    if (len == '0) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else if (mode == MODE_COPY) begin
                        state_d = ST_RD;
                        busy_d  = 1'b1;
                        addr_d  = src_addr;
                    end else begin
                        state_d = ST_WR;
                        busy_d  = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = dst_addr;
                        din_d   = fill_val;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
                busy_d  = 1'b1;
            end
            ST_CAP: begin
                // RAM output now holds the byte at src_q; capture it for the write.
                state_d = ST_WR;
                busy_d  = 1'b1;
                we_d    = 1'b1;
                addr_d  = dst_q;
                din_d   = mem_dout;
            end
            ST_WR: begin
                src_d = src_q + AW'(1);
                dst_d = dst_q + AW'(1);
                rem_d = rem_q - (AW+1)'(1);
                if (rem_q == (AW+1)'(1)) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end else if (mode_q == MODE_COPY) begin
                    state_d = ST_RD;
                    busy_d  = 1'b1;
                    addr_d  = src_q + AW'(1);
                end else begin
                    busy_d  = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = dst_q + AW'(1);
                    din_d   = fill_q;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench: engine on RAM port A, bench-driven loader/checker on port B.
module tb_mem_copy_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] src_addr, dst_addr, fill_val;
    logic [8:0] len;
    logic       busy, done, mem_we;
    logic [7:0] mem_addr, mem_din, mem_dout;
    logic [7:0] add_b, din_b, dout_b;
    logic       we_b;

    int checks = 0;
    int errors = 0;

    // Per-command observation log filled by run_cmd.
    int         done_cyc, done_cnt, we_cnt;
    logic [31:0] we_pat;
    logic [7:0] wr_addr [0:31];
    logic [7:0] rd;

    always #5 clk = ~clk;

    mem_copy_engine dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_val(fill_val), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout)
    );

    dp_ram #(.AW(8), .DW(8)) ram (
        .clk(clk),
        .add_a(mem_addr), .din_a(mem_din), .we_a(mem_we), .dout_a(mem_dout),
        .add_b(add_b), .din_b(din_b), .we_b(we_b), .dout_b(dout_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ram_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        add_b = a; din_b = d; we_b = 1'b1;
        @(negedge clk);
        we_b = 1'b0;
    endtask

    task automatic ram_rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        add_b = a; we_b = 1'b0;
        @(negedge clk);
        d = dout_b;
    endtask

    // Issue one command, then sample for 'window' cycles; k=1 is the cycle
    // right after the start-sampling edge. inj_at>0 pulses a rogue start.
    task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [8:0] l, input logic [7:0] f,
                           input int window, input int inj_at);
        @(negedge clk);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f;
        @(negedge clk);
        start = 1'b0;
        done_cyc = -1; done_cnt = 0; we_cnt = 0; we_pat = '0;
        for (int k = 1; k <= window; k++) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (mem_we) begin
                if (we_cnt < 32) wr_addr[we_cnt] = mem_addr;
                we_cnt++;
            end
            if (k <= 32) we_pat[k-1] = mem_we;
            start = (k == inj_at);
            if (k == inj_at) begin
                mode = 1'b1; dst_addr = 8'h80; len = 9'd1; fill_val = 8'hEE;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_val = '0; add_b = '0; din_b = '0; we_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_din", 32'(mem_din), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) ram_wr(8'(i), 8'h00);

        // Fill 4 bytes at 0x10
        run_cmd(1'b1, 8'h00, 8'h10, 9'd4, 8'hA5, 8, 0);
        check("fill_done_cyc", 32'(done_cyc), 32'd5);
        check("fill_done_cnt", 32'(done_cnt), 32'd1);
        check("fill_we_cnt", 32'(we_cnt), 32'd4);
        check("fill_we_pat", we_pat, 32'h0000_000F);
        for (int i = 0; i < 4; i++) check("fill_wr_addr", 32'(wr_addr[i]), 32'(8'h10 + 8'(i)));
        for (int i = 0; i < 4; i++) begin
            ram_rd(8'(8'h10 + 8'(i)), rd);
            check("fill_data", 32'(rd), 32'hA5);
        end
        ram_rd(8'h14, rd);
        check("fill_untouched", 32'(rd), 32'h00);

        // Copy 3 bytes 0x20 -> 0x40
        ram_wr(8'h20, 8'h11); ram_wr(8'h21, 8'h22); ram_wr(8'h22, 8'h33);
        run_cmd(1'b0, 8'h20, 8'h40, 9'd3, 8'h00, 12, 0);
        check("copy_done_cyc", 32'(done_cyc), 32'd10);
        check("copy_done_cnt", 32'(done_cnt), 32'd1);
        check("copy_we_pat", we_pat, 32'h0000_0124);
        ram_rd(8'h40, rd); check("copy_40", 32'(rd), 32'h11);
        ram_rd(8'h41, rd); check("copy_41", 32'(rd), 32'h22);
        ram_rd(8'h42, rd); check("copy_42", 32'(rd), 32'h33);

        // Fill across the top of the address space
        run_cmd(1'b1, 8'h00, 8'hFE, 9'd4, 8'h5C, 8, 0);
        check("wrap_a0", 32'(wr_addr[0]), 32'hFE);
        check("wrap_a1", 32'(wr_addr[1]), 32'hFF);
        check("wrap_a2", 32'(wr_addr[2]), 32'h00);
        check("wrap_a3", 32'(wr_addr[3]), 32'h01);
        ram_rd(8'hFE, rd); check("wrap_fe", 32'(rd), 32'h5C);
        ram_rd(8'h01, rd); check("wrap_01", 32'(rd), 32'h5C);
        ram_rd(8'h02, rd); check("wrap_02", 32'(rd), 32'h00);

        // Zero-length command
        run_cmd(1'b0, 8'h20, 8'h60, 9'd0, 8'h00, 4, 0);
        check("len0_done_cyc", 32'(done_cyc), 32'd1);
        check("len0_done_cnt", 32'(done_cnt), 32'd1);
        check("len0_we_cnt", 32'(we_cnt), 32'd0);

        // Start while busy is ignored
        for (int i = 0; i < 8; i++) ram_wr(8'(8'h60 + 8'(i)), 8'(8'h70 + 8'(i)));
        run_cmd(1'b0, 8'h60, 8'h90, 9'd8, 8'h00, 28, 5);
        check("busy_done_cyc", 32'(done_cyc), 32'd25);
        check("busy_done_cnt", 32'(done_cnt), 32'd1);
        check("busy_we_cnt", 32'(we_cnt), 32'd8);
        ram_rd(8'h80, rd); check("busy_80", 32'(rd), 32'h00);
        for (int i = 0; i < 8; i++) begin
            ram_rd(8'(8'h90 + 8'(i)), rd);
            check("busy_copy", 32'(rd), 32'(8'h70 + 8'(i)));
        end

        // Reset after the third write
        @(negedge clk);
        start = 1'b1; mode = 1'b1; dst_addr = 8'h30; len = 9'd10; fill_val = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        begin
            int n;
            bit hit;
            n = 0; hit = 1'b0;
            for (int k = 0; k < 20 && !hit; k++) begin
                if (mem_we) n++;
                if (n == 3) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check("rstmid_busy", 32'(busy), 32'd0);
                    check("rstmid_done", 32'(done), 32'd0);
                    check("rstmid_we", 32'(mem_we), 32'd0);
                    rst = 1'b0;
                    hit = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
            check("rstmid_reached", 32'(hit), 32'd1);
        end
        ram_rd(8'h30, rd); check("rstmid_30", 32'(rd), 32'hFF);
        ram_rd(8'h32, rd); check("rstmid_32", 32'(rd), 32'hFF);
        ram_rd(8'h33, rd); check("rstmid_33", 32'(rd), 32'h00);

        // Overlapping forward copy propagates the first byte
        ram_wr(8'h50, 8'h01); ram_wr(8'h51, 8'h02);
        run_cmd(1'b0, 8'h50, 8'h51, 9'd2, 8'h00, 10, 0);
        check("ovl_done_cyc", 32'(done_cyc), 32'd7);
        ram_rd(8'h50, rd); check("ovl_50", 32'(rd), 32'h01);
        ram_rd(8'h51, rd); check("ovl_51", 32'(rd), 32'h01);
        ram_rd(8'h52, rd); check("ovl_52", 32'(rd), 32'h01);

        // Full-array fill, len = 256
        run_cmd(1'b1, 8'h00, 8'h00, 9'd256, 8'h3C, 260, 0);
        check("full_done_cyc", 32'(done_cyc), 32'd257);
        check("full_we_cnt", 32'(we_cnt), 32'd256);
        ram_rd(8'h00, rd); check("full_00", 32'(rd), 32'h3C);
        ram_rd(8'h7F, rd); check("full_7f", 32'(rd), 32'h3C);
        ram_rd(8'hFF, rd); check("full_ff", 32'(rd), 32'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
